arb8_sched: RTL

- 8-requester arbiter that shares one resource between up to 8 clients. It registers a one-hot grant plus a 3-bit binary grant index.
- Two arbitration modes:
  - Fixed priority: highest index wins, i.e. the winner is the requester an 8:3 priority encoder would select.
  - Round-robin.
- Holds a grant until the owner releases it, or until a hold timeout expires while other requests are pending.
- Sits between client request lines and a shared bus/port mux; gnt_id drives the mux select directly.

---
 rtl/arb8_sched_pkg.sv | 17 +
 rtl/arb8_sched_if.sv | 15 +
 rtl/arb8_sched_prio_pick8.sv | 19 +
 rtl/arb8_sched.sv | 119 +++++++++++
 4 files changed

// File: rtl/arb8_sched_pkg.sv
// Shared definitions for the 8-client grant arbiter: sizes, FSM states and
// the gnt_id value presented while no client owns the resource.
package arb8_sched_pkg;

  localparam int N   = 8;
  localparam int IDW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [IDW-1:0] idle_id();
    return '0;
  endfunction

endpackage

// File: rtl/arb8_sched_if.sv
// Request/grant bundle between the clients (master) and the arbiter (slave).
interface arb8_sched_if;
  import arb8_sched_pkg::*;

  logic [N-1:0]   req;
  logic           rr_en;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic           preempt;

  modport master (output req, rr_en, input gnt, gnt_id, gnt_vld, preempt);
  modport slave  (input req, rr_en, output gnt, gnt_id, gnt_vld, preempt);

endinterface

// File: rtl/arb8_sched_prio_pick8.sv
// Combinational 8-bit picker: the highest set index wins; vld flags a non-empty set.
module prio_pick8
  import arb8_sched_pkg::*;
(
  input  logic [N-1:0]   c,
  output logic [IDW-1:0] idx,
  output logic           vld
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (c[i]) idx = IDW'(i);
    end
  end

  assign vld = |c;

endmodule

// File: rtl/arb8_sched.sv
// 8-requester arbiter with fixed-priority / round-robin selection, grant hold
// until release, and timeout preemption when other clients are waiting.
module arb8_sched
  import arb8_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  arb8_sched_if.slave bus
);

  localparam logic [HW-1:0] CNT_MAX = HW'(MAX_HOLD - 1);

  state_t         state, state_nxt;
  logic [HW-1:0]  cnt, cnt_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [N-1:0]   gnt_q, gnt_nxt;
  logic [IDW-1:0] id_q, id_nxt;
  logic           vld_q, vld_nxt;
  logic           pre_q, pre_nxt;

  logic [N-1:0]   cand, rr_vec;
  logic [IDW-1:0] fix_id, rr_k, win_id;
  logic           fix_vld, rr_vld, win_vld;
  logic           holder_req, others, at_max, take;

  // The holder is never a candidate; when idle gnt_q is zero so this is just req.
  assign cand = bus.req & ~gnt_q;

  // Bit k of rr_vec is client (ptr - k): k=7 maps to ptr+1, so the picker's
  // highest-index preference becomes "first set bit upward from ptr+1".
  always_comb begin
    rr_vec = '0;
    for (int k = 0; k < N; k++) begin
      rr_vec[k] = cand[ptr - IDW'(k)];
    end
  end

  prio_pick8 u_fix (.c(cand),   .idx(fix_id), .vld(fix_vld));
  prio_pick8 u_rr  (.c(rr_vec), .idx(rr_k),   .vld(rr_vld));

  assign win_id  = bus.rr_en ? (ptr - rr_k) : fix_id;
  assign win_vld = bus.rr_en ? rr_vld : fix_vld;

  assign holder_req = bus.req[id_q];
  assign others     = |cand;
  assign at_max     = (cnt == CNT_MAX);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    vld_nxt   = vld_q;
    pre_nxt   = 1'b0;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_vld) take = 1'b1;
      end
      ST_GRANT: begin
        if (!holder_req) begin
          if (win_vld) begin
            take = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
            id_nxt    = idle_id();
            vld_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end else if (at_max && others) begin
          take    = 1'b1;
          pre_nxt = 1'b1;
        end else if (!at_max) begin
          cnt_nxt = cnt + HW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (take) begin
      state_nxt = ST_GRANT;
      gnt_nxt   = N'(1) << win_id;
      id_nxt    = win_id;
      vld_nxt   = 1'b1;
      cnt_nxt   = '0;
      ptr_nxt   = win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= '1;
      gnt_q <= '0;
      id_q  <= idle_id();
      vld_q <= 1'b0;
      pre_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      gnt_q <= gnt_nxt;
      id_q  <= id_nxt;
      vld_q <= vld_nxt;
      pre_q <= pre_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.gnt_vld = vld_q;
  assign bus.preempt = pre_q;

endmodule
